clock_ctrl: RTL and testbench

- Run/step/halt controller directly upstream of the clock generator; drives that generator's ENABLE input.
- Turns operator controls (RUN level, STEP button) and the CPU's HALT flag into a clean, glitch-free ENABLE.
- Counts enabled cycles and enforces an optional cycle budget, so CPU test benches terminate deterministically.

---
 rtl/clock_ctrl.sv | 90 +++++++++
 tb/tb_clock_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Run/step/halt controller feeding the clock generator's enable; ENABLE is decoded purely from registered state.
// One-edge latency from RUN/STEP/HALT to ENABLE; optional cycle budget forces a sticky-timeout halt.
module clock_ctrl #(
    parameter int CW       = 32,
    parameter int STEP_LEN = 1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          RUN,
    input  logic          STEP,
    input  logic          HALT,
    input  logic          CLEAR,
    input  logic [CW-1:0] MAX_CYCLES,
    output logic          ENABLE,
    output logic [CW-1:0] CYCLES,
    output logic          HALTED,
    output logic          TIMEOUT
);
    localparam int SW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_STEPPING,
        S_HALTED
    } state_t;

    state_t        state;
    logic [SW-1:0] step_cnt;
    logic          step_q;
    logic          step_pulse;
    logic          budget_hit;
    logic [CW:0]   cyc_inc;

    assign step_pulse = STEP & ~step_q;
    assign cyc_inc    = {1'b0, CYCLES} + {{CW{1'b0}}, 1'b1};
    // Compare in CW+1 bits so a saturated counter still sees the budget as reached.
    assign budget_hit = ENABLE && (MAX_CYCLES != '0) && (cyc_inc >= {1'b0, MAX_CYCLES});

    assign ENABLE = (state == S_RUNNING) || (state == S_STEPPING);
    assign HALTED = (state == S_HALTED);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= S_IDLE;
            CYCLES   <= '0;
            TIMEOUT  <= 1'b0;
            step_cnt <= '0;
            step_q   <= 1'b0;
        end else begin
            step_q <= STEP;
            if (ENABLE && (CYCLES != '1))
                CYCLES <= cyc_inc[CW-1:0];

            if (HALT && (state != S_HALTED)) begin
                state <= S_HALTED;
            end else if (budget_hit) begin
                state   <= S_HALTED;
                TIMEOUT <= 1'b1;
            end else begin
                case (state)
                    S_HALTED: begin
                        if (CLEAR && !HALT)
                            state <= S_IDLE;
                    end
                    S_IDLE: begin
                        // RUN takes priority; a coincident step edge is dropped.
                        if (RUN) begin
                            state <= S_RUNNING;
                        end else if (step_pulse) begin
                            state    <= S_STEPPING;
                            step_cnt <= SW'(STEP_LEN - 1);
                        end
                    end
                    S_RUNNING: begin
                        if (!RUN)
                            state <= S_IDLE;
                    end
                    S_STEPPING: begin
                        if (step_cnt == '0)
                            state <= S_IDLE;
                        else
                            step_cnt <= step_cnt - SW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clock_ctrl.sv
// Randomized plus directed bench for clock_ctrl; a behavioural model predicts outputs after each edge
// and a separate monitor compares them against the DUT through an expectation queue.
module tb_clock_ctrl;
    localparam int CW   = 8;
    localparam int SL   = 3;
    localparam int CMAX = 255;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          RUN   = 1'b0;
    logic          STEP  = 1'b0;
    logic          HALT  = 1'b0;
    logic          CLEAR = 1'b0;
    logic [CW-1:0] MAX_CYCLES = '0;
    logic          ENABLE;
    logic [CW-1:0] CYCLES;
    logic          HALTED;
    logic          TIMEOUT;

    clock_ctrl #(.CW(CW), .STEP_LEN(SL)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .HALT(HALT),
        .CLEAR(CLEAR), .MAX_CYCLES(MAX_CYCLES), .ENABLE(ENABLE), .CYCLES(CYCLES),
        .HALTED(HALTED), .TIMEOUT(TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        bit en;
        int cyc;
        bit hlt;
        bit to;
    } exp_t;

    exp_t expq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Model: "running" request latched, remaining step cycles, halted flag.
    bit m_run, m_halt, m_to, m_stepq;
    int m_left, m_cyc;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_edge();
        bit   en;
        int   nc;
        exp_t e;
        en = m_run || (m_left > 0);
        if (RESET) begin
            m_run = 0; m_halt = 0; m_to = 0; m_stepq = 0; m_left = 0; m_cyc = 0;
        end else begin
            nc = (en && m_cyc < CMAX) ? m_cyc + 1 : m_cyc;
            if (HALT && !m_halt) begin
                m_halt = 1; m_run = 0; m_left = 0;
            end else if (en && MAX_CYCLES != 0 && m_cyc + 1 >= int'(MAX_CYCLES)) begin
                m_halt = 1; m_to = 1; m_run = 0; m_left = 0;
            end else if (m_halt) begin
                if (CLEAR && !HALT) m_halt = 0;
            end else if (m_run) begin
                if (!RUN) m_run = 0;
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                if (RUN) m_run = 1;
                else if (STEP && !m_stepq) m_left = SL;
            end
            m_cyc   = nc;
            m_stepq = STEP;
        end
        e.en  = m_run || (m_left > 0);
        e.cyc = m_cyc;
        e.hlt = m_halt;
        e.to  = m_to;
        expq.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit run, input bit step, input bit halt,
                       input bit clear, input int maxc, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLOCK);
            RESET = rst; RUN = run; STEP = step; HALT = halt; CLEAR = clear;
            MAX_CYCLES = maxc[CW-1:0];
            model_edge();
        end
    endtask

    // Monitor: every edge the DUT presents a new output set.
    always begin
        exp_t e;
        @(posedge CLOCK);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("enable",  int'(ENABLE),  int'(e.en));
            check("cycles",  int'(CYCLES),  e.cyc);
            check("halted",  int'(HALTED),  int'(e.hlt));
            check("timeout", int'(TIMEOUT), int'(e.to));
        end
    end

    bit r_run, r_step, r_halt, r_clear, r_rst;
    int r_max;

    initial begin
        // Reset then free run for 10 edges.
        cyc(1, 0, 0, 0, 0, 0, 2);
        cyc(0, 1, 0, 0, 0, 0, 10);
        cyc(0, 0, 0, 0, 0, 0, 3);
        // Three step presses, each held for 5 edges.
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int p = 0; p < 3; p++) begin
            cyc(0, 0, 1, 0, 0, 0, 5);
            cyc(0, 0, 0, 0, 0, 0, 3);
        end
        // Budget of 25, clear, then resume past budget.
        cyc(1, 0, 0, 0, 0, 25, 1);
        cyc(0, 1, 0, 0, 0, 25, 30);
        cyc(0, 0, 0, 0, 1, 25, 1);
        cyc(0, 0, 0, 0, 0, 25, 1);
        cyc(0, 1, 0, 0, 0, 25, 4);
        cyc(0, 0, 0, 0, 1, 25, 1);
        // HALT mid-run, CLEAR while HALT held, then release.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 7);
        cyc(0, 1, 0, 1, 0, 0, 2);
        cyc(0, 1, 0, 1, 1, 0, 2);
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 2);
        // Reset mid-run with RUN still high.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 13);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 3);
        // RUN and STEP edge together from IDLE.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 4);
        cyc(0, 0, 0, 0, 0, 0, 5);
        // Counter saturation with no budget.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 262);
        cyc(0, 0, 0, 0, 0, 0, 2);
        // Randomized traffic.
        r_run = 0; r_step = 0; r_halt = 0; r_max = 0;
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) r_run = ~r_run;
            if ($urandom_range(0, 3) == 0) r_step = ~r_step;
            if (r_halt) begin
                if ($urandom_range(0, 2) == 0) r_halt = 0;
            end else if ($urandom_range(0, 39) == 0) begin
                r_halt = 1;
            end
            r_clear = ($urandom_range(0, 5) == 0);
            r_rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0)
                r_max = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
            cyc(r_rst, r_run, r_step, r_halt, r_clear, r_max, 1);
        end
        repeat (3) @(negedge CLOCK);
        check("drain", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
